// File: rtl/mem_bus_pkg.sv
// Shared types for the per-core memory bus initiator: port FSM states,
// the buffered request record and the bus widths.
package mem_bus_pkg;

   localparam int ADDR_WID = 32;
   localparam int DATA_WID = 32;
   localparam int BE_WID   = DATA_WID / 8;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_SLOT,
      RD_CAP,
      RSP
   } port_state_e;

   typedef struct packed {
      logic                we;
      logic [BE_WID-1:0]   be;
      logic [ADDR_WID-1:0] addr;
      logic [DATA_WID-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/mem_req_fifo.sv
// Request buffer between the core and the slot-driven issue logic.
// The head entry is read straight out of the storage registers.
module mem_req_fifo
   import mem_bus_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic     i_clk,
   input  logic     i_rst_n,
   input  logic     i_push,
   input  mem_req_t i_data,
   input  logic     i_pop,
   output logic     o_full,
   output logic     o_empty,
   output mem_req_t o_head
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   mem_req_t    r_mem [DEPTH];
   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   logic        w_push;
   logic        w_pop;

   // Extra pointer bit tells a full buffer apart from an empty one.
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
   assign w_pop   = i_pop && !o_empty;
   assign w_push  = i_push && (!o_full || w_pop);
   assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/mem_port.sv
// Per-core initiator on the time-sliced memory bus: buffers core requests,
// issues the head in this core's slot and returns responses in order.
//
// state     | meaning
// IDLE      | request buffer empty, nothing outstanding
// WAIT_SLOT | head request pending, waiting for a usable slot
// RD_CAP    | cycle after a load issue; read data captured at its end
// RSP       | response register full, held until the core accepts it
module mem_port
   import mem_bus_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_req_valid,
   output logic                o_req_ready,
   input  logic                i_req_we,
   input  logic [BE_WID-1:0]   i_req_be,
   input  logic [ADDR_WID-1:0] i_req_addr,
   input  logic [DATA_WID-1:0] i_req_wdata,
   output logic                o_rsp_valid,
   input  logic                i_rsp_ready,
   output logic                o_rsp_we,
   output logic [DATA_WID-1:0] o_rsp_rdata,
   input  logic                i_slot,
   output logic                o_mem_oe,
   output logic [BE_WID-1:0]   o_mem_we,
   output logic [ADDR_WID-1:0] o_mem_addr,
   output logic [DATA_WID-1:0] o_mem_wdata,
   input  logic [DATA_WID-1:0] i_mem_rdata
);

   port_state_e         r_state;
   logic                r_rsp_valid;
   logic                r_rsp_we;
   logic [DATA_WID-1:0] r_rsp_rdata;
   logic                w_full;
   logic                w_empty;
   logic                w_push;
   logic                w_rsp_free;
   logic                w_issue;
   mem_req_t            w_req;
   mem_req_t            w_head;

   assign w_req       = {i_req_we, i_req_be, i_req_addr, i_req_wdata};
   assign w_push      = i_req_valid && !w_full;
   assign o_req_ready = !w_full;

   mem_req_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_push),
      .i_data  (w_req),
      .i_pop   (w_issue),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_head)
   );

   // A slot is usable only if no read is in flight and the response
   // register is empty or being handed to the core this very cycle.
   assign w_rsp_free = (r_state != RD_CAP) && (!r_rsp_valid || i_rsp_ready);
   assign w_issue    = i_slot && !w_empty && w_rsp_free;

   assign o_mem_oe    = w_issue;
   assign o_mem_we    = (w_issue && w_head.we) ? w_head.be    : '0;
   assign o_mem_addr  = w_issue                ? w_head.addr  : '0;
   assign o_mem_wdata = (w_issue && w_head.we) ? w_head.wdata : '0;

   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_we    = r_rsp_we;
   assign o_rsp_rdata = r_rsp_rdata;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_rsp_valid <= 1'b0;
         r_rsp_we    <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         if (r_rsp_valid && i_rsp_ready) r_rsp_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_push) r_state <= WAIT_SLOT;
            end
            WAIT_SLOT, RSP: begin
               if (w_issue) begin
                  if (w_head.we) begin
                     r_state     <= RSP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_we    <= 1'b1;
                     r_rsp_rdata <= '0;
                  end else begin
                     r_state <= RD_CAP;
                  end
               end else if (r_state == RSP && i_rsp_ready) begin
                  r_state <= (!w_empty || w_push) ? WAIT_SLOT : IDLE;
               end
            end
            RD_CAP: begin
               r_state     <= RSP;
               r_rsp_valid <= 1'b1;
               r_rsp_we    <= 1'b0;
               r_rsp_rdata <= i_mem_rdata;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port.sv
// Bench for mem_port: slot every 16 cycles at phase 5, directed scenarios
// followed by random traffic, checked against a queue-based transaction model.
module tb_mem_port;
   import mem_bus_pkg::*;

   localparam int DEPTH    = 2;
   localparam int CORE_CNT = 16;
   localparam int SLOT_PH  = 5;
   localparam int N_CYC    = 1900;

   typedef struct {
      logic                we;
      logic [BE_WID-1:0]   be;
      logic [ADDR_WID-1:0] addr;
      logic [DATA_WID-1:0] wdata;
   } req_s;

   typedef struct {
      logic                we;
      logic [DATA_WID-1:0] rdata;
      int                  due;
   } rsp_s;

   logic                i_clk;
   logic                i_rst_n;
   logic                i_req_valid;
   logic                o_req_ready;
   logic                i_req_we;
   logic [BE_WID-1:0]   i_req_be;
   logic [ADDR_WID-1:0] i_req_addr;
   logic [DATA_WID-1:0] i_req_wdata;
   logic                o_rsp_valid;
   logic                i_rsp_ready;
   logic                o_rsp_we;
   logic [DATA_WID-1:0] o_rsp_rdata;
   logic                i_slot;
   logic                o_mem_oe;
   logic [BE_WID-1:0]   o_mem_we;
   logic [ADDR_WID-1:0] o_mem_addr;
   logic [DATA_WID-1:0] o_mem_wdata;
   logic [DATA_WID-1:0] i_mem_rdata;

   mem_port #(.FIFO_DEPTH(DEPTH)) u_dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_req_valid (i_req_valid),
      .o_req_ready (o_req_ready),
      .i_req_we    (i_req_we),
      .i_req_be    (i_req_be),
      .i_req_addr  (i_req_addr),
      .i_req_wdata (i_req_wdata),
      .o_rsp_valid (o_rsp_valid),
      .i_rsp_ready (i_rsp_ready),
      .o_rsp_we    (o_rsp_we),
      .o_rsp_rdata (o_rsp_rdata),
      .i_slot      (i_slot),
      .o_mem_oe    (o_mem_oe),
      .o_mem_we    (o_mem_we),
      .o_mem_addr  (o_mem_addr),
      .o_mem_wdata (o_mem_wdata),
      .i_mem_rdata (i_mem_rdata)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   int n_chk  = 0;
   int n_pass = 0;

   req_s src_q  [$];
   req_s pend_q [$];
   rsp_s rsp_q  [$];

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic chk_reset(input string tag);
      chk(tag, 128'({o_req_ready, o_rsp_valid, o_rsp_we, o_rsp_rdata,
                     o_mem_oe, o_mem_we, o_mem_addr, o_mem_wdata}),
               128'({1'b1, 1'b0, 1'b0, DATA_WID'(0),
                     1'b0, BE_WID'(0), ADDR_WID'(0), DATA_WID'(0)}));
   endtask

   function automatic req_s mk(input logic we, input logic [ADDR_WID-1:0] a,
                               input logic [DATA_WID-1:0] d, input logic [BE_WID-1:0] be);
      req_s r;
      r.we = we; r.addr = a; r.wdata = d; r.be = be;
      return r;
   endfunction

   initial begin
      req_s                h;
      rsp_s                r;
      bit                  vis;
      bit                  exp_issue;
      bit                  acc;
      int                  last_ld;
      logic [BE_WID-1:0]   e_be;
      logic [DATA_WID-1:0] e_wd;

      i_rst_n = 1'b0; i_req_valid = 1'b0; i_req_we = 1'b0; i_req_be = '0;
      i_req_addr = '0; i_req_wdata = '0; i_rsp_ready = 1'b1; i_slot = 1'b0;
      i_mem_rdata = '0;
      last_ld = -10;
      repeat (2) @(negedge i_clk);
      #1 chk_reset("reset_values");
      @(negedge i_clk);
      i_rst_n = 1'b1;

      for (int cyc = 0; cyc < N_CYC; cyc++) begin
         case (cyc)
            2:   src_q.push_back(mk(1'b0, 32'h40, 32'h0, 4'h0));
            5:   src_q.push_back(mk(1'b1, 32'h10, 32'h12345678, 4'hF));
            24: begin
               src_q.push_back(mk(1'b0, 32'h100, 32'h0, 4'h0));
               src_q.push_back(mk(1'b1, 32'h104, 32'hA5A5A5A5, 4'h3));
               src_q.push_back(mk(1'b0, 32'h108, 32'h0, 4'hC));
            end
            75:  src_q.push_back(mk(1'b0, 32'h80, 32'h0, 4'h0));
            90:  src_q.push_back(mk(1'b1, 32'h84, 32'hCAFEF00D, 4'h5));
            125: src_q.push_back(mk(1'b0, 32'h90, 32'h0, 4'h0));
            default: ;
         endcase
         if (cyc >= 200 && cyc < 1700 && src_q.size() < 2 && $urandom_range(2) == 0)
            src_q.push_back(mk(1'($urandom_range(1)), $urandom, $urandom, BE_WID'($urandom)));

         if (cyc == 134) i_rst_n = 1'b0;
         if (cyc == 136) i_rst_n = 1'b1;

         i_slot = (cyc % CORE_CNT == SLOT_PH);
         if (cyc < 200)       i_rsp_ready = !(cyc >= 80 && cyc <= 105);
         else if (cyc < 1700) i_rsp_ready = ($urandom_range(3) != 0);
         else                 i_rsp_ready = 1'b1;
         i_mem_rdata = (cyc == 6) ? 32'hDEADBEEF : DATA_WID'($urandom);
         i_req_valid = (src_q.size() > 0) && i_rst_n;
         if (src_q.size() > 0) begin
            i_req_we = src_q[0].we; i_req_be = src_q[0].be;
            i_req_addr = src_q[0].addr; i_req_wdata = src_q[0].wdata;
         end else begin
            i_req_we = 1'($urandom_range(1)); i_req_be = BE_WID'($urandom);
            i_req_addr = $urandom; i_req_wdata = $urandom;
         end
         if (cyc == last_ld + 1 && rsp_q.size() > 0)
            rsp_q[rsp_q.size()-1].rdata = i_mem_rdata;
         #1;

         if (!i_rst_n) begin
            chk_reset("reset_mid_op");
            src_q.delete(); pend_q.delete(); rsp_q.delete();
            last_ld = -10;
         end else begin
            vis = (rsp_q.size() > 0) && (cyc >= rsp_q[0].due);
            chk("req_ready", 128'(o_req_ready), 128'(pend_q.size() < DEPTH));
            chk("rsp_valid", 128'(o_rsp_valid), 128'(vis));
            if (vis) begin
               chk("rsp_we", 128'(o_rsp_we), 128'(rsp_q[0].we));
               chk("rsp_rdata", 128'(o_rsp_rdata), 128'(rsp_q[0].rdata));
            end
            exp_issue = i_slot && (pend_q.size() > 0) &&
                        ((rsp_q.size() == 0) || (vis && i_rsp_ready));
            if (exp_issue) begin
               h = pend_q[0];
               e_be = h.we ? h.be : '0;
               e_wd = h.we ? h.wdata : '0;
               chk("bus_issue", 128'({o_mem_oe, o_mem_we, o_mem_addr, o_mem_wdata}),
                                128'({1'b1, e_be, h.addr, e_wd}));
            end else begin
               chk("bus_idle", 128'({o_mem_oe, o_mem_we, o_mem_addr, o_mem_wdata}), 128'(0));
            end

            case (cyc)
               5:   chk("tp_load_drive", 128'({o_mem_oe, o_mem_we, o_mem_addr}), 128'({1'b1, 4'h0, 32'h40}));
               7:   chk("tp_load_rsp", 128'({o_rsp_valid, o_rsp_rdata}), 128'({1'b1, 32'hDEADBEEF}));
               21:  chk("tp_store_drive", 128'({o_mem_oe, o_mem_we, o_mem_addr, o_mem_wdata}),
                                          128'({1'b1, 4'hF, 32'h10, 32'h12345678}));
               22:  chk("tp_store_rsp", 128'({o_rsp_valid, o_rsp_we, o_rsp_rdata}), 128'({1'b1, 1'b1, 32'h0}));
               26:  chk("tp_fifo_full", 128'(o_req_ready), 128'(0));
               101: chk("tp_blocked_slot", 128'({o_mem_oe, o_rsp_valid}), 128'({1'b0, 1'b1}));
               117: chk("tp_unblocked_slot", 128'({o_mem_oe, o_mem_addr}), 128'({1'b1, 32'h84}));
               default: ;
            endcase

            acc = i_req_valid && (pend_q.size() < DEPTH);
            if (vis && i_rsp_ready) void'(rsp_q.pop_front());
            if (exp_issue) begin
               h = pend_q.pop_front();
               r.we = h.we; r.rdata = '0;
               r.due = cyc + (h.we ? 1 : 2);
               rsp_q.push_back(r);
               if (!h.we) last_ld = cyc;
            end
            if (acc) pend_q.push_back(src_q.pop_front());
         end
         @(negedge i_clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
